// File: rtl/ts_qracc_bitserial.sv
// Bit-serial QR in-memory compute column array: 1-bit weight matrix, per-column saturating ADC
// model, and a shift-add accumulator processing one activation bit-plane per cycle, LSB first.
module ts_qracc_bitserial #(
  parameter int unsigned numRows    = 128,
  parameter int unsigned numCols    = 8,
  parameter int unsigned numAdcBits = 4,
  parameter int unsigned numInBits  = 4,
  localparam int unsigned RW = $clog2(numRows),
  localparam int unsigned SW = $clog2(numRows + 1),
  localparam int unsigned OW = numAdcBits + numInBits
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wr_en,
  input  logic [RW-1:0]                 wr_row,
  input  logic [numCols-1:0]            wr_data,
  output logic                          wr_drop,
  input  logic                          rd_en,
  input  logic [RW-1:0]                 rd_row,
  output logic [numCols-1:0]            rd_data,
  output logic                          rd_valid,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [numRows*numInBits-1:0]  in_act,
  input  logic [SW-1:0]                 adc_shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [numCols*OW-1:0]         out_data,
  output logic [numCols-1:0]            out_sat
);

  localparam int unsigned BW      = (numInBits > 1) ? $clog2(numInBits) : 1;
  localparam int unsigned MaxCode = (1 << numAdcBits) - 1;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e                         state_q;
  logic [numCols-1:0]             mem_q [numRows];
  logic [numRows*numInBits-1:0]   act_q;
  logic [SW-1:0]                  shift_q;
  logic [BW-1:0]                  bit_idx_q;
  logic [OW-1:0]                  acc_q [numCols];
  logic [numCols-1:0]             sat_q;

  logic [numAdcBits-1:0]          code [numCols];
  logic [numCols-1:0]             sat_now;
  logic                           wr_ok;
  logic                           rd_ok;

  assign wr_ok     = (32'(wr_row) < numRows);
  assign rd_ok     = (32'(rd_row) < numRows);
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_sat   = sat_q;

  always_comb begin
    for (int j = 0; j < numCols; j++) begin
      out_data[j*OW +: OW] = acc_q[j];
    end
  end

  // Per-column popcount of the current bit-plane against the stored weights, then ADC clamp.
  always_comb begin
    logic [SW-1:0] cnt;
    logic [SW-1:0] shifted;
    for (int j = 0; j < numCols; j++) begin
      cnt = '0;
      for (int r = 0; r < numRows; r++) begin
        cnt = cnt + SW'(act_q[r*numInBits + 32'(bit_idx_q)] & mem_q[r][j]);
      end
      shifted    = cnt >> shift_q;
      sat_now[j] = (32'(shifted) > MaxCode);
      code[j]    = sat_now[j] ? numAdcBits'(MaxCode) : numAdcBits'(shifted);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      act_q     <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      sat_q     <= '0;
      wr_drop   <= 1'b0;
      for (int j = 0; j < numCols; j++) acc_q[j] <= '0;
    end else begin
      wr_drop <= wr_en && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            act_q     <= in_act;
            shift_q   <= adc_shift;
            bit_idx_q <= '0;
            sat_q     <= '0;
            for (int j = 0; j < numCols; j++) acc_q[j] <= '0;
            state_q   <= StCompute;
          end
        end
        StCompute: begin
          for (int j = 0; j < numCols; j++) begin
            acc_q[j] <= acc_q[j] + (OW'(code[j]) << bit_idx_q);
          end
          sat_q     <= sat_q | sat_now;
          bit_idx_q <= bit_idx_q + 1'b1;
          if (32'(bit_idx_q) == numInBits - 1) state_q <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Weight array is deliberately not reset; contents survive RST.
  always_ff @(posedge CLK) begin
    if (!RST && (state_q == StIdle) && wr_en && wr_ok) begin
      mem_q[wr_row] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= (rd_en && rd_ok) ? mem_q[rd_row] : '0;
    end
  end

endmodule

// File: tb/tb_ts_qracc_bitserial.sv
// Directed bench for ts_qracc_bitserial: a behavioural weight/MAC model fills a scoreboard
// at each accepted activation vector, and results are popped when out_valid appears.
module tb_ts_qracc_bitserial;

  localparam int NR = 128;
  localparam int NC = 8;
  localparam int NA = 4;
  localparam int NI = 4;
  localparam int RW = 7;
  localparam int SW = 8;
  localparam int OW = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic              wr_en;
  logic [RW-1:0]     wr_row;
  logic [NC-1:0]     wr_data;
  logic              wr_drop;
  logic              rd_en;
  logic [RW-1:0]     rd_row;
  logic [NC-1:0]     rd_data;
  logic              rd_valid;
  logic              in_valid;
  logic              in_ready;
  logic [NR*NI-1:0]  in_act;
  logic [SW-1:0]     adc_shift;
  logic              out_valid;
  logic              out_ready;
  logic [NC*OW-1:0]  out_data;
  logic [NC-1:0]     out_sat;

  ts_qracc_bitserial #(
    .numRows    (NR),
    .numCols    (NC),
    .numAdcBits (NA),
    .numInBits  (NI)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .wr_drop   (wr_drop),
    .rd_en     (rd_en),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .adc_shift (adc_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NC-1:0]    sat;
    logic [NC*OW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [NC-1:0] mm [NR];
  int            n_vec = 0;
  int            n_err = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t model(input logic [NR*NI-1:0] act, input int sh);
    exp_t e;
    int   cnt, v, acc;
    e = '0;
    for (int j = 0; j < NC; j++) begin
      acc = 0;
      for (int b = 0; b < NI; b++) begin
        cnt = 0;
        for (int r = 0; r < NR; r++) begin
          if (act[r*NI+b] && mm[r][j]) cnt++;
        end
        v = cnt >> sh;
        if (v > (1 << NA) - 1) begin
          e.sat[j] = 1'b1;
          v = (1 << NA) - 1;
        end
        acc += v << b;
      end
      e.data[j*OW +: OW] = OW'(acc);
    end
    return e;
  endfunction

  function automatic logic [NR*NI-1:0] fill_act(input int v);
    logic [NR*NI-1:0] a;
    for (int r = 0; r < NR; r++) a[r*NI +: NI] = NI'(v);
    return a;
  endfunction

  function automatic logic [NR*NI-1:0] rand_act();
    logic [NR*NI-1:0] a;
    for (int r = 0; r < NR; r++) a[r*NI +: NI] = NI'($urandom);
    return a;
  endfunction

  task automatic write_row(input int r, input logic [NC-1:0] d);
    wr_en = 1'b1; wr_row = RW'(r); wr_data = d;
    tick();
    wr_en = 1'b0;
    mm[r] = d;
  endtask

  task automatic read_check(input string tag, input int r, input logic [NC-1:0] e);
    rd_en = 1'b1; rd_row = RW'(r);
    tick();
    rd_en = 1'b0;
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd1);
    check({tag, "_rd_data"}, 64'(rd_data), 64'(e));
  endtask

  task automatic start_mac(input logic [NR*NI-1:0] act, input int sh);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_act = act; adc_shift = SW'(sh);
    sb.push_back(model(act, sh));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 32) begin
      tick();
      lat++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_out_data"}, 64'(out_data), 64'(e.data));
      check({tag, "_out_sat"}, 64'(out_sat), 64'(e.sat));
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_released_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_released_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int               lat;
    logic [NC*OW-1:0] held;
    logic [NR*NI-1:0] a;

    RST = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; rd_en = 1'b0; rd_row = '0;
    in_valid = 1'b0; in_act = '0; adc_shift = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_wr_drop", 64'(wr_drop), 64'd0);
    RST = 1'b0;
    tick();

    // T1: full array of ones, every count saturates the ADC
    for (int r = 0; r < NR; r++) write_row(r, 8'hFF);
    start_mac(fill_act(1), 3);
    wait_done("t1", lat);
    check("t1_const_data", 64'(out_data), 64'h0F0F_0F0F_0F0F_0F0F);
    check("t1_const_sat", 64'(out_sat), 64'hFF);
    release_out("t1");

    // T2: ten rows feed column 0 only, checks first-result latency
    for (int r = 0; r < NR; r++) write_row(r, (r < 10) ? 8'h01 : 8'h00);
    start_mac(fill_act(3), 0);
    wait_done("t2", lat);
    check("t2_latency", 64'(lat), 64'd4);
    check("t2_const_data", 64'(out_data), 64'd30);
    check("t2_const_sat", 64'(out_sat), 64'd0);
    release_out("t2");

    // T3: result held while the consumer stalls and the producer keeps toggling
    start_mac(rand_act(), 1);
    wait_done("t3", lat);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      in_act = rand_act();
      adc_shift = SW'($urandom_range(0, 4));
      tick();
      check("t3_hold_data", 64'(out_data), 64'(held));
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    release_out("t3");

    // T4: reset mid-MAC abandons it but keeps the weights
    start_mac(fill_act(3), 0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    void'(sb.pop_back());
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_in_ready", 64'(in_ready), 64'd1);
    check("t4_out_data", 64'(out_data), 64'd0);
    check("t4_out_sat", 64'(out_sat), 64'd0);
    for (int r = 0; r < 10; r++) read_check("t4_keep", r, 8'h01);

    // T5: write during COMPUTE is dropped and does not disturb the MAC
    start_mac(rand_act(), 0);
    wr_en = 1'b1; wr_row = RW'(5); wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("t5_wr_drop_pulse", 64'(wr_drop), 64'd1);
    tick();
    check("t5_wr_drop_clear", 64'(wr_drop), 64'd0);
    wait_done("t5", lat);
    release_out("t5");
    read_check("t5_row5", 5, 8'h01);

    // T6: read-during-write returns old data
    write_row(7, 8'h00);
    rd_en = 1'b1; rd_row = RW'(7);
    wr_en = 1'b1; wr_row = RW'(7); wr_data = 8'h5A;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    mm[7] = 8'h5A;
    check("t6_rd_valid", 64'(rd_valid), 64'd1);
    check("t6_old_data", 64'(rd_data), 64'h00);
    read_check("t6_new", 7, 8'h5A);

    // Write in the accepting cycle lands before compute
    wr_en = 1'b1; wr_row = RW'(0); wr_data = 8'h3C;
    mm[0] = 8'h3C;
    start_mac(rand_act(), 1);
    wr_en = 1'b0;
    wait_done("wr_accept", lat);
    release_out("wr_accept");

    // Random weights and activations across several ADC ranges
    for (int r = 0; r < NR; r++) write_row(r, 8'($urandom));
    for (int k = 0; k < 6; k++) begin
      a = rand_act();
      start_mac(a, k);
      wait_done("rand", lat);
      check("rand_latency", 64'(lat), 64'd4);
      release_out("rand");
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
